// File: rtl/dma_pkg.sv
// DMA FIFO shared package.
// Width defaults, flag levels, pointer width helper.
package dma_pkg;

  localparam int DMA_DATA_W = 16;
  localparam int DMA_DEPTH  = 8;
  localparam int DMA_AF_LVL = 6;
  localparam int DMA_AE_LVL = 2;

  function automatic int dma_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// DMA FIFO storage: DEPTH x DATA_W register array.
// One sync write port, one registered read port.
module dma_fifo_mem
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = DMA_DEPTH,
  localparam int AW    = dma_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read register: old word wins on same-slot write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dma_fifo.sv
// DMA FIFO: circular buffer, pointers, count, flags.
// Optional sticky ovf/udf under DMA_FIFO_ERR_EN.
module dma_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = DMA_DEPTH,
  parameter int AF_LVL = DMA_AF_LVL,
  parameter int AE_LVL = DMA_AE_LVL,
  localparam int AW    = dma_aw(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
`ifdef DMA_FIFO_ERR_EN
  input  logic              err_clr,
  output logic              ovf,
  output logic              udf,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count
);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_n, rd_ptr_n;
  logic [AW:0] count_n;
  logic        wr_acc, rd_acc;
  logic        full_n, empty_n;

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // next pointers and count
  always_comb begin
    wr_ptr_n = wr_ptr + CW'(wr_acc);
    rd_ptr_n = rd_ptr + CW'(rd_acc);
    count_n  = count;
    unique case (1'b1)
      wr_acc & ~rd_acc: count_n = count + 1'b1;
      rd_acc & ~wr_acc: count_n = count - 1'b1;
      default:          count_n = count;
    endcase
  end

  assign empty_n = wr_ptr_n == rd_ptr_n;
  assign full_n  =
    (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &
    (wr_ptr_n[AW] != rd_ptr_n[AW]);

  // pointers, count and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= count_n >= CW'(AF_LVL);
      almost_empty <= count_n <= CW'(AE_LVL);
      rd_valid     <= rd_acc;
    end
  end

`ifdef DMA_FIFO_ERR_EN
  // sticky errors; set wins over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_acc) ovf <= 1'b1;
      else if (err_clr)           ovf <= 1'b0;
      if (rd_en & empty)          udf <= 1'b1;
      else if (err_clr)           udf <= 1'b0;
    end
  end
`endif

  dma_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_dma_fifo.sv
// Directed bench for dma_fifo (DEPTH=8).
// Expected values are hand-computed constants.
module tb_dma_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] data_in;
  logic        rd_en;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        full, empty;
  logic        almost_full, almost_empty;
  logic [3:0]  count;
`ifdef DMA_FIFO_ERR_EN
  logic        err_clr;
  logic        ovf, udf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
`ifdef DMA_FIFO_ERR_EN
    .err_clr      (err_clr),
    .ovf          (ovf),
    .udf          (udf),
`endif
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        w,
    input logic [15:0] d,
    input logic        r
  );
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    step();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_rv"}, rd_valid, 0);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
`ifdef DMA_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    step();
    chk_idle("reset");

    // fill to full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 1'b0);
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 6);
      chk("fill_ae", almost_empty, (i + 1) <= 2);
      chk("fill_full", full, i == 7);
      chk("fill_empty", empty, 0);
    end
    drive(1'b1, 16'hBEEF, 1'b0);
    chk("drop_count", count, 8);
    chk("drop_full", full, 1);
`ifdef DMA_FIFO_ERR_EN
    chk("ovf_set", ovf, 1);
`endif

    // drain in order; BEEF must not appear
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      chk("drain_dout", data_out, 16'hA000 + 16'(i));
      chk("drain_rv", rd_valid, 1);
      chk("drain_count", count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    drive(1'b0, 16'h0, 1'b1);
    chk("udf_rv", rd_valid, 0);
    chk("udf_dout", data_out, 16'hA007);
    chk("udf_count", count, 0);
`ifdef DMA_FIFO_ERR_EN
    chk("udf_set", udf, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("udf_clr", udf, 0);
`endif
    step();
    chk("idle_rv", rd_valid, 0);

    // wrap: 3 ahead, then 12 pairs
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'hC000 + 16'(i), 1'b0);
    chk("wrap_pre", count, 3);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 16'hC003 + 16'(k), 1'b1);
      chk("wrap_dout", data_out, 16'hC000 + 16'(k));
      chk("wrap_rv", rd_valid, 1);
      chk("wrap_count", count, 3);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      chk("wrap_tail", data_out, 16'hC00C + 16'(i));
    end
    chk("wrap_empty", empty, 1);

    // full with simultaneous push/pop
    for (int i = 0; i < 8; i++)
      drive(1'b1, 16'hD000 + 16'(i), 1'b0);
    chk("fp_full", full, 1);
    drive(1'b1, 16'h1234, 1'b1);
    chk("fp_dout", data_out, 16'hD000);
    chk("fp_count", count, 8);
    chk("fp_full2", full, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      chk("fp_drain", data_out,
          (i == 7) ? 16'h1234 : 16'hD001 + 16'(i));
    end
    chk("fp_empty", empty, 1);

    // empty with simultaneous push/pop
    drive(1'b1, 16'h5555, 1'b1);
    chk("ep_count", count, 1);
    chk("ep_rv", rd_valid, 0);
    chk("ep_empty", empty, 0);
    drive(1'b0, 16'h0, 1'b1);
    chk("ep_dout", data_out, 16'h5555);
    chk("ep_rv2", rd_valid, 1);

    // async reset mid-burst at count=5
    for (int i = 0; i < 5; i++)
      drive(1'b1, 16'hE000 + 16'(i), 1'b0);
    chk("mid_count", count, 5);
    #2 rst = 1'b1;
    #1;
    chk_idle("midrst");
    #1 rst = 1'b0;

    drive(1'b1, 16'hF000, 1'b0);
    drive(1'b1, 16'hF001, 1'b0);
    chk("post_count", count, 2);
    drive(1'b0, 16'h0, 1'b1);
    chk("post_dout", data_out, 16'hF000);
    chk("post_count2", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
